// File: rtl/slave_resume_signal_gen_if.sv
// -----------------------------------------------------------------------------
// slave_resume_signal_gen_if
// Bundles the control and line signals of the remote-wakeup (resume) generator.
//   slave  modport : the generator itself (qualifiers, request, line state and
//                    grant in; TX request, output enable, line drive, status out)
//   master modport : the surrounding slave control / TX arbiter side
// Line encoding on lineStateIn / txLineOut: 00 SE0, 01 J, 10 K, 11 SE1.
// -----------------------------------------------------------------------------
interface slave_resume_signal_gen_if;
    logic       suspendedIn;
    logic       remoteWakeEnIn;
    logic       wakeReqIn;
    logic [1:0] lineStateIn;
    logic       txGntIn;
    logic       txReqOut;
    logic       txOEOut;
    logic [1:0] txLineOut;
    logic       busyOut;
    logic       resumeDoneOut;
    logic       abortOut;

    modport slave (
        input  suspendedIn, remoteWakeEnIn, wakeReqIn, lineStateIn, txGntIn,
        output txReqOut, txOEOut, txLineOut, busyOut, resumeDoneOut, abortOut
    );

    modport master (
        output suspendedIn, remoteWakeEnIn, wakeReqIn, lineStateIn, txGntIn,
        input  txReqOut, txOEOut, txLineOut, busyOut, resumeDoneOut, abortOut
    );
endinterface

// File: rtl/slave_resume_signal_gen.sv
// -----------------------------------------------------------------------------
// slave_resume_signal_gen
// USB device remote-wakeup generator. On a qualified request while suspended it
// waits for IDLE_CYCLES consecutive J cycles, requests the line from the TX
// arbiter, drives K for RESUME_CYCLES cycles, then releases the line.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - slave_resume_signal_gen_if.slave (qualifiers, request, line state,
//          grant in; txReqOut/txOEOut/txLineOut/busyOut decoded from state;
//          resumeDoneOut/abortOut registered one-cycle pulses)
// -----------------------------------------------------------------------------
module slave_resume_signal_gen #(
    parameter int unsigned IDLE_CYCLES   = 240000,
    parameter int unsigned RESUME_CYCLES = 96000
) (
    input  logic                      clk,
    input  logic                      rst,
    slave_resume_signal_gen_if.slave  bus
);

    localparam logic [1:0]  LINE_J      = 2'b01;
    localparam logic [1:0]  LINE_K      = 2'b10;
    localparam logic [23:0] IDLE_LAST   = 24'(IDLE_CYCLES - 1);
    localparam logic [23:0] RESUME_LAST = 24'(RESUME_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IDLE = 3'd1,
        REQ       = 3'd2,
        DRIVE_K   = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    state_t      stateR;
    state_t      stateNextS;
    logic [23:0] cntR;
    logic [23:0] cntNextS;
    logic        doneR;
    logic        doneNextS;
    logic        abortR;
    logic        abortNextS;

    // State, shared counter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateR <= IDLE;
            cntR   <= 24'd0;
            doneR  <= 1'b0;
            abortR <= 1'b0;
        end else begin
            stateR <= stateNextS;
            cntR   <= cntNextS;
            doneR  <= doneNextS;
            abortR <= abortNextS;
        end
    end

    // Next-state, counter and pulse decode. The counter is reused: it counts
    // consecutive J cycles in WAIT_IDLE and K cycles in DRIVE_K.
    always_comb begin
        stateNextS = stateR;
        cntNextS   = cntR;
        doneNextS  = 1'b0;
        abortNextS = 1'b0;
        case (stateR)
            IDLE: begin
                cntNextS = 24'd0;
                if (bus.wakeReqIn && bus.suspendedIn && bus.remoteWakeEnIn) begin
                    stateNextS = WAIT_IDLE;
                end else begin
                    stateNextS = IDLE;
                end
            end
            WAIT_IDLE: begin
                // A host resume takes priority over completing the idle count.
                if (!bus.suspendedIn) begin
                    stateNextS = IDLE;
                    cntNextS   = 24'd0;
                    abortNextS = 1'b1;
                end else if (bus.lineStateIn == LINE_J) begin
                    if (cntR == IDLE_LAST) begin
                        stateNextS = REQ;
                        cntNextS   = 24'd0;
                    end else begin
                        cntNextS = cntR + 24'd1;
                    end
                end else begin
                    cntNextS = 24'd0;
                end
            end
            REQ: begin
                // Abort beats a grant arriving on the same cycle.
                if (!bus.suspendedIn) begin
                    stateNextS = IDLE;
                    cntNextS   = 24'd0;
                    abortNextS = 1'b1;
                end else if (bus.txGntIn) begin
                    stateNextS = DRIVE_K;
                    cntNextS   = 24'd0;
                end else begin
                    stateNextS = REQ;
                end
            end
            DRIVE_K: begin
                // Grant or suspend drops are deliberately ignored: once K has
                // started it always runs for the full duration.
                if (cntR == RESUME_LAST) begin
                    stateNextS = RELEASE;
                    cntNextS   = 24'd0;
                    doneNextS  = 1'b1;
                end else begin
                    cntNextS = cntR + 24'd1;
                end
            end
            RELEASE: begin
                stateNextS = IDLE;
                cntNextS   = 24'd0;
            end
            default: begin
                stateNextS = IDLE;
                cntNextS   = 24'd0;
            end
        endcase
    end

    assign bus.txReqOut      = (stateR == REQ) || (stateR == DRIVE_K);
    assign bus.txOEOut       = (stateR == DRIVE_K);
    assign bus.txLineOut     = (stateR == DRIVE_K) ? LINE_K : LINE_J;
    assign bus.busyOut       = (stateR != IDLE);
    assign bus.resumeDoneOut = doneR;
    assign bus.abortOut      = abortR;

endmodule

// File: tb/tb_slave_resume_signal_gen.sv
// -----------------------------------------------------------------------------
// tb_slave_resume_signal_gen
// Table-driven bench for slave_resume_signal_gen with IDLE_CYCLES = 8 and
// RESUME_CYCLES = 16. Each record holds inputs applied for one or more cycles
// and the expected phase/pulse seen just after each clock edge. A hand-written
// sequence then measures request latency, K length and pulse counts.
// -----------------------------------------------------------------------------
module tb_slave_resume_signal_gen;

    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;
    localparam logic [1:0] SE0 = 2'b00;

    typedef enum int {P_IDLE, P_WI, P_REQ, P_DK, P_REL} phase_t;

    typedef struct {
        string      name;
        int         reps;
        logic       rst;
        logic       wake;
        logic       susp;
        logic       en;
        logic [1:0] line;
        logic       gnt;
        phase_t     ph;
        logic       abrt;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    slave_resume_signal_gen_if ifc();

    slave_resume_signal_gen #(
        .IDLE_CYCLES   (8),
        .RESUME_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    function automatic void add(string nm, int reps, logic r, logic w, logic s,
                                logic e, logic [1:0] ln, logic g, phase_t ph,
                                logic ab);
        vec_t v;
        v.name = nm; v.reps = reps; v.rst = r; v.wake = w; v.susp = s;
        v.en = e; v.line = ln; v.gnt = g; v.ph = ph; v.abrt = ab;
        vecs.push_back(v);
    endfunction

    // Expected {txReq, txOE, txLine[1:0], busy, resumeDone, abort}.
    function automatic logic [6:0] expOut(phase_t ph, logic ab);
        logic [6:0] r;
        case (ph)
            P_IDLE:  r = {1'b0, 1'b0, 2'b01, 1'b0, 1'b0, ab};
            P_WI:    r = {1'b0, 1'b0, 2'b01, 1'b1, 1'b0, ab};
            P_REQ:   r = {1'b1, 1'b0, 2'b01, 1'b1, 1'b0, ab};
            P_DK:    r = {1'b1, 1'b1, 2'b10, 1'b1, 1'b0, ab};
            P_REL:   r = {1'b0, 1'b0, 2'b01, 1'b1, 1'b1, ab};
            default: r = 7'h7f;
        endcase
        return r;
    endfunction

    task automatic checkOuts(string nm, int idx, logic [6:0] exp);
        logic [6:0] got;
        got = {ifc.txReqOut, ifc.txOEOut, ifc.txLineOut, ifc.busyOut,
               ifc.resumeDoneOut, ifc.abortOut};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s rep %0d: got {req,oe,line,busy,done,abort}=%b expected %b",
                     nm, idx, got, exp);
        end
    endtask

    task automatic checkInt(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    initial begin
        int lat;
        int oeCnt;
        int oeRuns;
        int doneCnt;
        int abortCnt;
        logic prevOe;

        clk = 1'b0; rst = 1'b1; checks = 0; errors = 0;
        ifc.wakeReqIn = 1'b0; ifc.suspendedIn = 1'b1; ifc.remoteWakeEnIn = 1'b1;
        ifc.lineStateIn = J; ifc.txGntIn = 1'b0;

        //   name         reps rst wake susp en line gnt expected     abort
        add("reset",        2, 1'b1, 1'b0, 1'b1, 1'b1, J,   1'b0, P_IDLE, 1'b0);
        add("resetWake",    1, 1'b1, 1'b1, 1'b1, 1'b1, J,   1'b1, P_IDLE, 1'b0);
        // nominal: grant present throughout
        add("nomReq",       1, 1'b0, 1'b1, 1'b1, 1'b1, J,   1'b1, P_WI,   1'b0);
        add("nomWait",      7, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_WI,   1'b0);
        add("nomReqPh",     1, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_REQ,  1'b0);
        add("nomK",        16, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_DK,   1'b0);
        add("nomRel",       1, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_REL,  1'b0);
        add("nomIdle",      2, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_IDLE, 1'b0);
        // qualifier gating
        add("gateEn",       1, 1'b0, 1'b1, 1'b1, 1'b0, J,   1'b1, P_IDLE, 1'b0);
        add("gateEnIdle",   2, 1'b0, 1'b0, 1'b1, 1'b0, J,   1'b1, P_IDLE, 1'b0);
        add("gateSusp",     1, 1'b0, 1'b1, 1'b0, 1'b1, J,   1'b1, P_IDLE, 1'b0);
        add("gateSuspIdle", 2, 1'b0, 1'b0, 1'b0, 1'b1, J,   1'b1, P_IDLE, 1'b0);
        // idle restart: 5 J, 1 K, then 8 J before REQ
        add("rsReq",        1, 1'b0, 1'b1, 1'b1, 1'b1, J,   1'b0, P_WI,   1'b0);
        add("rsJ",          5, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b0, P_WI,   1'b0);
        add("rsK",          1, 1'b0, 1'b0, 1'b1, 1'b1, K,   1'b0, P_WI,   1'b0);
        add("rsJ2",         7, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b0, P_WI,   1'b0);
        add("rsReqPh",      1, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b0, P_REQ,  1'b0);
        // grant withheld 20 cycles in REQ; line no longer watched
        add("gntWait",     19, 1'b0, 1'b0, 1'b1, 1'b1, SE0, 1'b0, P_REQ,  1'b0);
        add("gntK",         1, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_DK,   1'b0);
        add("kHold",        3, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_DK,   1'b0);
        add("kDrop",        3, 1'b0, 1'b0, 1'b0, 1'b1, J,   1'b0, P_DK,   1'b0);
        // reset during K cycle 7
        add("rstMid",       1, 1'b1, 1'b0, 1'b1, 1'b1, J,   1'b1, P_IDLE, 1'b0);
        add("rstAfter",     3, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_IDLE, 1'b0);
        // abort at WAIT_IDLE cycle 4
        add("abWReq",       1, 1'b0, 1'b1, 1'b1, 1'b1, J,   1'b0, P_WI,   1'b0);
        add("abWJ",         3, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b0, P_WI,   1'b0);
        add("abWDrop",      1, 1'b0, 1'b0, 1'b0, 1'b1, J,   1'b0, P_IDLE, 1'b1);
        add("abWAfter",     2, 1'b0, 1'b0, 1'b0, 1'b1, J,   1'b0, P_IDLE, 1'b0);
        // abort in REQ together with the grant
        add("abRReq",       1, 1'b0, 1'b1, 1'b1, 1'b1, J,   1'b0, P_WI,   1'b0);
        add("abRWait",      7, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b0, P_WI,   1'b0);
        add("abRReqPh",     1, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b0, P_REQ,  1'b0);
        add("abRHold",      2, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b0, P_REQ,  1'b0);
        add("abRDrop",      1, 1'b0, 1'b0, 1'b0, 1'b1, J,   1'b1, P_IDLE, 1'b1);
        add("abRAfter",     2, 1'b0, 1'b0, 1'b0, 1'b1, J,   1'b1, P_IDLE, 1'b0);
        // abort together with the final idle count
        add("abFReq",       1, 1'b0, 1'b1, 1'b1, 1'b1, J,   1'b0, P_WI,   1'b0);
        add("abFWait",      7, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b0, P_WI,   1'b0);
        add("abFDrop",      1, 1'b0, 1'b0, 1'b0, 1'b1, J,   1'b0, P_IDLE, 1'b1);
        add("abFAfter",     1, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b0, P_IDLE, 1'b0);
        // request while busy, then back-to-back acceptance
        add("bzReq",        1, 1'b0, 1'b1, 1'b1, 1'b1, J,   1'b1, P_WI,   1'b0);
        add("bzWait",       7, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_WI,   1'b0);
        add("bzReqPh",      1, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_REQ,  1'b0);
        add("bzK1",         6, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_DK,   1'b0);
        add("bzKWake",      1, 1'b0, 1'b1, 1'b1, 1'b1, J,   1'b1, P_DK,   1'b0);
        add("bzK2",         9, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_DK,   1'b0);
        add("bzRel",        1, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_REL,  1'b0);
        add("b2bIdle",      1, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_IDLE, 1'b0);
        add("b2bReq",       1, 1'b0, 1'b1, 1'b1, 1'b1, J,   1'b1, P_WI,   1'b0);
        add("b2bAbort",     1, 1'b0, 1'b0, 1'b0, 1'b1, J,   1'b1, P_IDLE, 1'b1);
        add("b2bEnd",       2, 1'b0, 1'b0, 1'b1, 1'b1, J,   1'b1, P_IDLE, 1'b0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].reps; k++) begin
                rst                = vecs[i].rst;
                ifc.wakeReqIn      = vecs[i].wake;
                ifc.suspendedIn    = vecs[i].susp;
                ifc.remoteWakeEnIn = vecs[i].en;
                ifc.lineStateIn    = vecs[i].line;
                ifc.txGntIn        = vecs[i].gnt;
                @(posedge clk);
                #1;
                checkOuts(vecs[i].name, k, expOut(vecs[i].ph, vecs[i].abrt));
            end
        end

        // Hand-written nominal run: latency to txReq, K length and pulse counts.
        rst = 1'b0; ifc.suspendedIn = 1'b1; ifc.remoteWakeEnIn = 1'b1;
        ifc.lineStateIn = J; ifc.txGntIn = 1'b1; ifc.wakeReqIn = 1'b1;
        @(posedge clk);
        #1;
        ifc.wakeReqIn = 1'b0;
        lat = 1;
        while (!ifc.txReqOut && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkInt("reqLatency", lat, 9);

        oeCnt = 0; oeRuns = 0; doneCnt = 0; abortCnt = 0; prevOe = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (ifc.txOEOut) oeCnt++;
            if (ifc.txOEOut && !prevOe) oeRuns++;
            if (ifc.resumeDoneOut) doneCnt++;
            if (ifc.resumeDoneOut && !prevOe) checkInt("doneAfterLastK", 0, 1);
            if (ifc.abortOut) abortCnt++;
            prevOe = ifc.txOEOut;
        end
        checkInt("kCycles", oeCnt, 16);
        checkInt("kRuns", oeRuns, 1);
        checkInt("donePulses", doneCnt, 1);
        checkInt("abortPulses", abortCnt, 0);
        checkInt("busyAtEnd", int'(ifc.busyOut), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slave_resume_signal_gen.md
# slave_resume_signal_gen

Transmit-side companion to the slave receive status monitor. It generates USB device remote-wakeup signalling: on request from the slave controller while suspended, it checks that the bus has been idle for the required time, then requests the line from the TX arbiter and drives K for a fixed duration. It sits between the slave control logic and the TX line-state mux, beside the slave receive status monitor.

## Interface
- IDLE_CYCLES, 240000, consecutive J-state cycles required before K may be driven (5 ms at 48 MHz); legal range 1..2^24-1
- RESUME_CYCLES, 96000, number of cycles K is driven (2 ms at 48 MHz); legal range 1..2^24-1
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- suspendedIn  in  1  device is in the suspended state
- remoteWakeEnIn  in  1  host has enabled remote wakeup
- wakeReqIn  in  1  single-cycle remote-wakeup request
- lineStateIn  in  2  received line state: 00 = SE0, 01 = J, 10 = K, 11 = SE1
- txGntIn  in  1  TX arbiter grant; level, held while owned
- txReqOut  out  1  line ownership request to TX arbiter
- txOEOut  out  1  transceiver output enable
- txLineOut  out  2  line state to drive, same encoding as lineStateIn
- busyOut  out  1  sequence in progress (any state except IDLE)
- resumeDoneOut  out  1  one-cycle pulse: K signalling completed
- abortOut  out  1  one-cycle pulse: sequence abandoned before K was driven

## Operation
- FSM states: IDLE, WAIT_IDLE, REQ, DRIVE_K, RELEASE. One 24-bit counter shared by WAIT_IDLE and DRIVE_K.
- IDLE: the block accepts a request when wakeReqIn = 1, suspendedIn = 1 and remoteWakeEnIn = 1, and moves to WAIT_IDLE with counter = 0. It silently ignores the request if either qualifier is 0. It also ignores wakeReqIn in every state other than IDLE; no queuing.
- WAIT_IDLE: counter increments on each cycle with lineStateIn = 01. Any other line state clears the counter to 0. When the counter reaches IDLE_CYCLES-1 on a J cycle, the FSM moves to REQ.
- REQ: txReqOut = 1. On the first cycle with txGntIn = 1, the FSM moves to DRIVE_K with counter = 0.
- Abort: if suspendedIn = 0 in WAIT_IDLE or REQ (the host resumed first), the FSM returns to IDLE and pulses abortOut on the same cycle. In that case resumeDoneOut does not pulse and K is never driven.
- DRIVE_K: txReqOut = 1, txOEOut = 1, txLineOut = 10. The counter increments every cycle. After exactly RESUME_CYCLES cycles in DRIVE_K, the FSM moves to RELEASE.
  - A drop of suspendedIn or txGntIn in DRIVE_K is ignored; the full K duration always completes.
- RELEASE: one cycle with txOEOut = 0 and txReqOut = 0. resumeDoneOut = 1 on that cycle. The FSM returns to IDLE.
- remoteWakeEnIn is sampled only in IDLE.
- lineStateIn is not monitored after WAIT_IDLE.
- txLineOut = 01 (J) in every state except DRIVE_K.

## Timing
- All outputs are registered, except txReqOut, txOEOut, txLineOut and busyOut, which decode directly from the state register.
- Reset values:
  - state = IDLE
  - counter = 0
  - txReqOut = 0
  - txOEOut = 0
  - txLineOut = 01
  - busyOut = 0
  - resumeDoneOut = 0
  - abortOut = 0
- rst asserted mid-sequence, including DRIVE_K, returns the FSM to IDLE on the next edge. txOEOut drops on that edge, and no pulse is generated.
- Request to WAIT_IDLE: 1 cycle.
- Minimum request-to-first-K cycle: 1 + IDLE_CYCLES + 1, with the line continuously J and the grant already present.
- txOEOut is high for exactly RESUME_CYCLES consecutive cycles per completed sequence.
- resumeDoneOut asserts the cycle after the last K cycle.
- Back-to-back sequences: a new wakeReqIn is accepted on the first IDLE cycle after RELEASE.
- Simultaneous abort and grant in REQ: abort wins.
- Simultaneous abort and final idle count in WAIT_IDLE: abort wins.

## Test plan
Use IDLE_CYCLES = 8 and RESUME_CYCLES = 16 for all scenarios.
- Nominal: hold the line at J, suspendedIn = 1, remoteWakeEnIn = 1. Pulse wakeReqIn, grant immediately. Required response:
  - txReqOut goes high 9 cycles after the request.
  - txOEOut is high for exactly 16 cycles with txLineOut = 10.
  - resumeDoneOut pulses once, then busyOut = 0.
- Idle restart: the line is J for 5 cycles, K for 1 cycle, then J continuously. Required response: REQ is entered only after 8 consecutive J cycles following the K.
- Qualifier gating: with remoteWakeEnIn = 0 (and separately with suspendedIn = 0), pulse wakeReqIn. Required response: busyOut stays 0 and there are no pulses.
- Abort: drop suspendedIn at cycle 4 of WAIT_IDLE, and separately while waiting for grant in REQ. Required response:
  - abortOut pulses once on that cycle.
  - txOEOut never asserts.
  - The FSM is in IDLE on the next cycle.
- Grant delay and in-flight reset:
  - Withhold txGntIn for 20 cycles. Required response: the K phase starts on the grant cycle +1.
  - Assert rst at K cycle 7. Required response: txOEOut = 0 and busyOut = 0 on the next cycle, and resumeDoneOut never pulses.
- Request while busy: pulse wakeReqIn during DRIVE_K. Required response: it is ignored, and exactly one resumeDoneOut pulse occurs.
